// File: rtl/cp0_pkg.sv
`default_nettype none
// cp0_pkg: CP0 register map, control-op and exception codes, vectors and FSM states.
// Rev 1.0
package cp0_pkg;

  localparam logic [4:0] CR_COUNT   = 5'd9;
  localparam logic [4:0] CR_COMPARE = 5'd11;
  localparam logic [4:0] CR_STATUS  = 5'd12;
  localparam logic [4:0] CR_CAUSE   = 5'd13;
  localparam logic [4:0] CR_EPC     = 5'd14;
  localparam logic [4:0] CR_PRID    = 5'd15;

  localparam logic [1:0] OP_NOP  = 2'd0;
  localparam logic [1:0] OP_WRCR = 2'd1;
  localparam logic [1:0] OP_EXRT = 2'd2;

  localparam int EXC_NOEXP  = 0;
  localparam int EXC_EXTINT = 1;
  localparam int EXC_TIMER  = 2;
  localparam int EXC_TRAP   = 3;
  localparam int EXC_CP2    = 4;

  localparam logic [31:0] INT_VECTOR = 32'h0000_0080;
  localparam logic [31:0] DF_VECTOR  = 32'h0000_0100;

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_REDIRECT = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/cp0_exc_ctrl_if.sv
`default_nettype none
// cp0_exc_ctrl_if: pipeline <-> CP0 bus; master is the pipeline, slave is the CP0 block.
// Rev 1.0
interface cp0_exc_ctrl_if #(
  parameter int IRQ_CH     = 6,
  parameter int NEST_DEPTH = 2,
  parameter int EXP_W      = 3
);
  localparam int LVL_W = $clog2(NEST_DEPTH + 1);

  logic [IRQ_CH-1:0] irq;
  logic              stall;
  logic              mem_en;
  logic [31:0]       mem_pc;
  logic [EXP_W-1:0]  mem_exp_code;
  logic [1:0]        mem_ctrl_op;
  logic [4:0]        mem_cr_addr;
  logic [31:0]       mem_cr_wdata;
  logic [4:0]        cr_rd_addr;
  logic [31:0]       cr_rd_data;
  logic              int_detect;
  logic [EXP_W-1:0]  int_code;
  logic              redirect;
  logic [31:0]       new_pc;
  logic [LVL_W-1:0]  exc_level;
  logic              double_fault;

  modport master (
    output irq, stall, mem_en, mem_pc, mem_exp_code, mem_ctrl_op,
           mem_cr_addr, mem_cr_wdata, cr_rd_addr,
    input  cr_rd_data, int_detect, int_code, redirect, new_pc,
           exc_level, double_fault
  );

  modport slave (
    input  irq, stall, mem_en, mem_pc, mem_exp_code, mem_ctrl_op,
           mem_cr_addr, mem_cr_wdata, cr_rd_addr,
    output cr_rd_data, int_detect, int_code, redirect, new_pc,
           exc_level, double_fault
  );
endinterface
`default_nettype wire

// File: rtl/cp0_exc_ctrl_stack.sv
`default_nettype none
// cp0_exc_stack: LIFO of {epc, code, ie} saved on exception entry; level = entry count.
// Rev 1.0
module cp0_exc_stack #(
  parameter int DEPTH = 2,
  parameter int EXP_W = 3,
  parameter int LVL_W = 2
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             push,
  input  wire logic             pop,
  input  wire logic [31:0]      push_epc,
  input  wire logic [EXP_W-1:0] push_code,
  input  wire logic             push_ie,
  input  wire logic             top_we,
  input  wire logic [31:0]      top_wdata,
  output logic      [31:0]      top_epc,
  output logic      [EXP_W-1:0] top_code,
  output logic                  top_ie,
  output logic                  full,
  output logic                  empty,
  output logic      [LVL_W-1:0] level
);
  logic [31:0]      r_epc  [DEPTH];
  logic [EXP_W-1:0] r_code [DEPTH];
  logic             r_ie   [DEPTH];
  logic [LVL_W-1:0] r_level;
  logic [LVL_W-1:0] w_top;

  assign w_top    = r_level - 1'b1;
  assign full     = (r_level == LVL_W'(DEPTH));
  assign empty    = (r_level == '0);
  assign level    = r_level;
  assign top_epc  = empty ? '0 : r_epc[w_top];
  assign top_code = empty ? '0 : r_code[w_top];
  assign top_ie   = empty ? 1'b0 : r_ie[w_top];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_level <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_epc[i]  <= '0;
        r_code[i] <= '0;
        r_ie[i]   <= 1'b0;
      end
    end else begin
      if (push && !full)
        r_level <= r_level + 1'b1;
      else if (pop && !empty)
        r_level <= r_level - 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        if (push && !full && r_level == LVL_W'(i)) begin
          r_epc[i]  <= push_epc;
          r_code[i] <= push_code;
          r_ie[i]   <= push_ie;
        end else if (top_we && !empty && r_level == LVL_W'(i + 1)) begin
          r_epc[i] <= top_wdata;
        end
      end
    end
  end
endmodule
`default_nettype wire

// File: rtl/cp0_exc_ctrl.sv
`default_nettype none
// cp0_exc_ctrl: CP0 registers, interrupt detect and nested exception commit beside MEM.
// Rev 1.0. Build option CP0_TIMER_EN implements COUNT/COMPARE and the timer interrupt.
module cp0_exc_ctrl
  import cp0_pkg::*;
#(
  parameter int          IRQ_CH     = 6,
  parameter int          NEST_DEPTH = 2,
  parameter int          EXP_W      = 3,
  parameter logic [31:0] PRID_VAL   = 32'h0001_0000
) (
  input wire logic         clk,
  input wire logic         reset,
  cp0_exc_ctrl_if.slave    bus
);
  localparam int LVL_W = $clog2(NEST_DEPTH + 1);

  state_t            r_state;
  logic              r_ie;
  logic [IRQ_CH-1:0] r_mask;
  logic [IRQ_CH-1:0] r_ip;
  logic [EXP_W-1:0]  r_code;
  logic              r_redirect;
  logic [31:0]       r_new_pc;
  logic              r_df;

  logic              w_commit, w_entry, w_ret, w_wrcr, w_det;
  logic              w_full, w_empty, w_top_ie;
  logic [31:0]       w_top_epc, w_push_epc, w_rd, w_status, w_cause;
  logic [EXP_W-1:0]  w_top_code;
  logic [LVL_W-1:0]  w_level;
  logic [31:0]       w_count, w_compare;
  logic              w_tp;

  assign w_commit   = (r_state == ST_RUN) && bus.mem_en && !bus.stall;
  assign w_entry    = w_commit && (bus.mem_exp_code != EXP_W'(EXC_NOEXP));
  assign w_ret      = w_commit && !w_entry && (bus.mem_ctrl_op == OP_EXRT) && !w_empty;
  assign w_wrcr     = w_commit && !w_entry && (bus.mem_ctrl_op == OP_WRCR);
  // TRAP resumes after the trapping instruction; faults and interrupts re-execute it.
  assign w_push_epc = (bus.mem_exp_code == EXP_W'(EXC_TRAP)) ? bus.mem_pc + 32'd4 : bus.mem_pc;

  cp0_exc_stack #(.DEPTH(NEST_DEPTH), .EXP_W(EXP_W), .LVL_W(LVL_W)) u_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (w_entry),
    .pop       (w_ret),
    .push_epc  (w_push_epc),
    .push_code (r_code),
    .push_ie   (r_ie),
    .top_we    (w_wrcr && bus.mem_cr_addr == CR_EPC),
    .top_wdata (bus.mem_cr_wdata),
    .top_epc   (w_top_epc),
    .top_code  (w_top_code),
    .top_ie    (w_top_ie),
    .full      (w_full),
    .empty     (w_empty),
    .level     (w_level)
  );

`ifdef CP0_TIMER_EN
  logic [31:0] r_count, r_compare;
  logic        r_tp;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count   <= '0;
      r_compare <= '0;
      r_tp      <= 1'b0;
    end else begin
      r_count <= (w_wrcr && bus.mem_cr_addr == CR_COUNT) ? bus.mem_cr_wdata : r_count + 32'd1;
      if (w_wrcr && bus.mem_cr_addr == CR_COMPARE) begin
        r_compare <= bus.mem_cr_wdata;
        r_tp      <= 1'b0;
      end else if (r_count == r_compare && r_compare != '0) begin
        r_tp <= 1'b1;
      end
    end
  end
  assign w_count   = r_count;
  assign w_compare = r_compare;
  assign w_tp      = r_tp;
`else
  assign w_count   = '0;
  assign w_compare = '0;
  assign w_tp      = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_RUN;
      r_ie       <= 1'b0;
      r_mask     <= '0;
      r_ip       <= '0;
      r_code     <= '0;
      r_redirect <= 1'b0;
      r_new_pc   <= '0;
      r_df       <= 1'b0;
    end else begin
      r_ip <= bus.irq;
      case (r_state)
        ST_RUN: begin
          if (w_entry) begin
            r_code     <= bus.mem_exp_code;
            r_ie       <= 1'b0;
            r_df       <= r_df | w_full;
            r_new_pc   <= w_full ? DF_VECTOR : INT_VECTOR;
            r_redirect <= 1'b1;
            r_state    <= ST_REDIRECT;
          end else if (w_ret) begin
            r_ie       <= w_top_ie;
            r_code     <= w_top_code;
            r_new_pc   <= w_top_epc;
            r_redirect <= 1'b1;
            r_state    <= ST_REDIRECT;
          end else if (w_wrcr) begin
            if (bus.mem_cr_addr == CR_STATUS) begin
              r_ie   <= bus.mem_cr_wdata[0];
              r_mask <= bus.mem_cr_wdata[8 +: IRQ_CH];
            end else if (bus.mem_cr_addr == CR_CAUSE) begin
              r_code <= bus.mem_cr_wdata[EXP_W-1:0];
            end
            r_new_pc   <= bus.mem_pc + 32'd4;
            r_redirect <= 1'b1;
            r_state    <= ST_REDIRECT;
          end
        end
        ST_REDIRECT: begin
          r_redirect <= 1'b0;
          r_state    <= ST_RUN;
        end
        default: begin
          r_redirect <= 1'b0;
          r_state    <= ST_RUN;
        end
      endcase
    end
  end

  always_comb begin
    w_status                = '0;
    w_status[0]             = r_ie;
    w_status[8 +: IRQ_CH]   = r_mask;
    w_cause                 = '0;
    w_cause[EXP_W-1:0]      = r_code;
    w_cause[8 +: IRQ_CH]    = r_ip;
    w_cause[30]             = w_tp;
    case (bus.cr_rd_addr)
      CR_COUNT:   w_rd = w_count;
      CR_COMPARE: w_rd = w_compare;
      CR_STATUS:  w_rd = w_status;
      CR_CAUSE:   w_rd = w_cause;
      CR_EPC:     w_rd = w_empty ? '0 : w_top_epc;
      CR_PRID:    w_rd = PRID_VAL;
      default:    w_rd = '0;
    endcase
  end

  assign w_det             = r_ie && ((|(r_ip & ~r_mask)) || w_tp);
  assign bus.int_detect    = w_det;
  assign bus.int_code      = !w_det ? '0 : (w_tp ? EXP_W'(EXC_TIMER) : EXP_W'(EXC_EXTINT));
  assign bus.cr_rd_data    = w_rd;
  assign bus.redirect      = r_redirect;
  assign bus.new_pc        = r_new_pc;
  assign bus.exc_level     = w_level;
  assign bus.double_fault  = r_df;
endmodule
`default_nettype wire

// File: tb/tb_cp0_exc_ctrl.sv
`default_nettype none
// tb_cp0_exc_ctrl: directed vector table, hand-written corner sequences and random
// stimulus against a queue-based reference model of the CP0 exception rules.
module tb_cp0_exc_ctrl;
  localparam int IRQ_CH = 6;
  localparam int NEST   = 2;
  localparam int EXP_W  = 3;
  localparam logic [4:0] A_COUNT = 5'd9, A_COMPARE = 5'd11, A_STATUS = 5'd12;
  localparam logic [4:0] A_CAUSE = 5'd13, A_EPC = 5'd14, A_PRID = 5'd15;
  localparam logic [1:0] WRCR = 2'd1, EXRT = 2'd2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  cp0_exc_ctrl_if #(.IRQ_CH(IRQ_CH), .NEST_DEPTH(NEST), .EXP_W(EXP_W)) bus ();
  cp0_exc_ctrl #(.IRQ_CH(IRQ_CH), .NEST_DEPTH(NEST), .EXP_W(EXP_W),
                 .PRID_VAL(32'h0001_0000)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // Reference model state
  typedef struct { logic [31:0] epc; logic [2:0] code; logic ie; } ent_t;
  ent_t        q[$];
  logic        m_ie, m_tp, m_df, m_redir;
  logic [5:0]  m_mask, m_ip;
  logic [2:0]  m_code;
  logic [31:0] m_npc, m_count, m_compare;

  task automatic model_reset();
    q.delete();
    m_ie = 0; m_tp = 0; m_df = 0; m_redir = 0; m_mask = '0; m_ip = '0;
    m_code = '0; m_npc = '0; m_count = '0; m_compare = '0;
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    logic [31:0] r;
    r = '0;
    case (a)
`ifdef CP0_TIMER_EN
      A_COUNT:   r = m_count;
      A_COMPARE: r = m_compare;
`endif
      A_STATUS:  begin r[0] = m_ie; r[13:8] = m_mask; end
      A_CAUSE:   begin r[2:0] = m_code; r[13:8] = m_ip; r[30] = m_tp; end
      A_EPC:     r = (q.size() > 0) ? q[q.size()-1].epc : 32'd0;
      A_PRID:    r = 32'h0001_0000;
      default:   r = '0;
    endcase
    return r;
  endfunction

  task automatic model_tick();
    logic commit, wr;
    ent_t e;
    commit  = !m_redir && bus.mem_en && !bus.stall;
    wr      = 0;
    m_redir = 0;
    if (commit) begin
      if (bus.mem_exp_code != 0) begin
        if (q.size() >= NEST) begin
          m_df = 1; m_npc = 32'h100;
        end else begin
          e.epc  = (bus.mem_exp_code == 3'd3) ? bus.mem_pc + 32'd4 : bus.mem_pc;
          e.code = m_code; e.ie = m_ie;
          q.push_back(e);
          m_npc = 32'h80;
        end
        m_code = bus.mem_exp_code; m_ie = 0; m_redir = 1;
      end else if (bus.mem_ctrl_op == EXRT && q.size() > 0) begin
        e = q.pop_back();
        m_ie = e.ie; m_code = e.code; m_npc = e.epc; m_redir = 1;
      end else if (bus.mem_ctrl_op == WRCR) begin
        wr = 1; m_redir = 1; m_npc = bus.mem_pc + 32'd4;
        if (bus.mem_cr_addr == A_STATUS) begin
          m_ie = bus.mem_cr_wdata[0]; m_mask = bus.mem_cr_wdata[13:8];
        end else if (bus.mem_cr_addr == A_CAUSE) begin
          m_code = bus.mem_cr_wdata[2:0];
        end else if (bus.mem_cr_addr == A_EPC && q.size() > 0) begin
          e = q.pop_back(); e.epc = bus.mem_cr_wdata; q.push_back(e);
        end
      end
    end
`ifdef CP0_TIMER_EN
    if (wr && bus.mem_cr_addr == A_COMPARE) begin
      m_tp = 0; m_compare = bus.mem_cr_wdata;
    end else if (m_count == m_compare && m_compare != 0) begin
      m_tp = 1;
    end
    m_count = (wr && bus.mem_cr_addr == A_COUNT) ? bus.mem_cr_wdata : m_count + 32'd1;
`endif
    m_ip = bus.irq;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    logic det;
    det = m_ie && ((|(m_ip & ~m_mask)) || m_tp);
    chk("redirect", 32'(bus.redirect), 32'(m_redir));
    if (m_redir) chk("new_pc", bus.new_pc, m_npc);
    chk("exc_level", 32'(bus.exc_level), 32'(q.size()));
    chk("double_fault", 32'(bus.double_fault), 32'(m_df));
    chk("int_detect", 32'(bus.int_detect), 32'(det));
    chk("int_code", 32'(bus.int_code), !det ? 32'd0 : (m_tp ? 32'd2 : 32'd1));
    chk("cr_rd_data", bus.cr_rd_data, model_read(bus.cr_rd_addr));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_tick();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle_mem();
    bus.mem_en = 0; bus.mem_exp_code = '0; bus.mem_ctrl_op = '0; bus.stall = 0;
  endtask

  task automatic drive(input logic [2:0] e, input logic [1:0] op, input logic [31:0] pc,
                       input logic [4:0] a, input logic [31:0] wd);
    bus.mem_en = 1; bus.mem_exp_code = e; bus.mem_ctrl_op = op;
    bus.mem_pc = pc; bus.mem_cr_addr = a; bus.mem_cr_wdata = wd;
  endtask

  task automatic do_reset();
    reset = 1; idle_mem(); bus.irq = '0; bus.mem_pc = '0;
    bus.mem_cr_addr = '0; bus.mem_cr_wdata = '0; bus.cr_rd_addr = A_STATUS;
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);
    reset = 0;
    #1;
    check_all();
    chk("reset_new_pc", bus.new_pc, 32'd0);
  endtask

  typedef struct {
    logic [2:0] e; logic [1:0] op; logic [31:0] pc; logic [4:0] a; logic [31:0] wd;
    logic redir; logic [31:0] npc; int lvl; logic [31:0] epc; logic [31:0] status; logic df;
  } vec_t;
  vec_t vt[9];
  logic [4:0] addr_pool[7];

  initial begin
    bus.irq = '0;
    idle_mem();
    do_reset();

    vt[0] = '{3'd0, WRCR, 32'h100, A_STATUS, 32'h1, 1'b1, 32'h104, 0, 32'h0,   32'h1, 1'b0};
    vt[1] = '{3'd3, 2'd0, 32'h200, 5'd0,     32'h0, 1'b1, 32'h80,  1, 32'h204, 32'h0, 1'b0};
    vt[2] = '{3'd0, EXRT, 32'h900, 5'd0,     32'h0, 1'b1, 32'h204, 0, 32'h0,   32'h1, 1'b0};
    vt[3] = '{3'd1, 2'd0, 32'h300, 5'd0,     32'h0, 1'b1, 32'h80,  1, 32'h300, 32'h0, 1'b0};
    vt[4] = '{3'd4, 2'd0, 32'h400, 5'd0,     32'h0, 1'b1, 32'h80,  2, 32'h400, 32'h0, 1'b0};
    vt[5] = '{3'd3, 2'd0, 32'h500, 5'd0,     32'h0, 1'b1, 32'h100, 2, 32'h400, 32'h0, 1'b1};
    vt[6] = '{3'd0, EXRT, 32'h904, 5'd0,     32'h0, 1'b1, 32'h400, 1, 32'h300, 32'h0, 1'b1};
    vt[7] = '{3'd0, EXRT, 32'h908, 5'd0,     32'h0, 1'b1, 32'h300, 0, 32'h0,   32'h1, 1'b1};
    vt[8] = '{3'd0, EXRT, 32'h90C, 5'd0,     32'h0, 1'b0, 32'h0,   0, 32'h0,   32'h1, 1'b1};

    for (int i = 0; i < 9; i++) begin
      drive(vt[i].e, vt[i].op, vt[i].pc, vt[i].a, vt[i].wd);
      cycle();
      idle_mem();
      chk("vec_redirect", 32'(bus.redirect), 32'(vt[i].redir));
      if (vt[i].redir) chk("vec_new_pc", bus.new_pc, vt[i].npc);
      chk("vec_level", 32'(bus.exc_level), 32'(vt[i].lvl));
      chk("vec_df", 32'(bus.double_fault), 32'(vt[i].df));
      bus.cr_rd_addr = A_EPC; #1;
      chk("vec_epc", bus.cr_rd_data, vt[i].epc);
      bus.cr_rd_addr = A_STATUS; #1;
      chk("vec_status", bus.cr_rd_data, vt[i].status);
      cycle();
      chk("vec_redirect_drop", 32'(bus.redirect), 32'd0);
    end

    // External interrupt: one cycle irq->IP, then masked via STATUS bit 10.
    bus.irq = 6'b000100;
    cycle();
    chk("irq_detect", 32'(bus.int_detect), 32'd1);
    chk("irq_code", 32'(bus.int_code), 32'd1);
    drive(3'd0, WRCR, 32'h180, A_STATUS, 32'h401);
    cycle();
    idle_mem();
    chk("irq_masked", 32'(bus.int_detect), 32'd0);
    cycle();

    // Stall holds a pending exception commit.
    bus.stall = 1;
    drive(3'd3, 2'd0, 32'h600, 5'd0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("stall_no_redirect", 32'(bus.redirect), 32'd0);
      chk("stall_level", 32'(bus.exc_level), 32'd0);
    end
    bus.stall = 0;
    cycle();
    idle_mem();
    chk("unstall_redirect", 32'(bus.redirect), 32'd1);
    chk("unstall_new_pc", bus.new_pc, 32'h80);
    chk("unstall_level", 32'(bus.exc_level), 32'd1);
    cycle();
    drive(3'd0, EXRT, 32'h80, 5'd0, 32'h0);
    cycle();
    idle_mem();
    chk("stall_ret_pc", bus.new_pc, 32'h604);
    cycle();
    drive(3'd0, EXRT, 32'h84, 5'd0, 32'h0);
    cycle();
    idle_mem();
    chk("exrt_lvl0_no_redirect", 32'(bus.redirect), 32'd0);
    cycle();

    // Random traffic against the model.
    addr_pool = '{A_COUNT, A_COMPARE, A_STATUS, A_CAUSE, A_EPC, A_PRID, 5'd3};
    for (int n = 0; n < 400; n++) begin
      bus.irq          = 6'($urandom);
      bus.stall        = ($urandom_range(0, 3) == 0);
      bus.mem_en       = 1'($urandom_range(0, 1));
      bus.mem_exp_code = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(1, 4)) : 3'd0;
      bus.mem_ctrl_op  = 2'($urandom);
      bus.mem_cr_addr  = addr_pool[$urandom_range(0, 6)];
      bus.mem_cr_wdata = $urandom;
      bus.mem_pc       = $urandom & 32'hFFFF_FFFC;
      bus.cr_rd_addr   = addr_pool[$urandom_range(0, 6)];
      cycle();
    end

    do_reset();
`ifdef CP0_TIMER_EN
    drive(3'd0, WRCR, 32'h40, A_COMPARE, 32'd20);
    cycle();
    idle_mem();
    for (int k = 0; k < 60 && m_count != 32'd21; k++) cycle();
    bus.cr_rd_addr = A_CAUSE; #1;
    chk("timer_tp_set", 32'(bus.cr_rd_data[30]), 32'd1);
    drive(3'd0, WRCR, 32'h44, A_COMPARE, 32'd40);
    cycle();
    idle_mem();
    chk("timer_tp_cleared", 32'(bus.cr_rd_data[30]), 32'd0);
    for (int k = 0; k < 60 && m_count != 32'd40; k++) cycle();
    drive(3'd0, WRCR, 32'h48, A_COMPARE, 32'd100);
    cycle();
    idle_mem();
    chk("timer_write_wins", 32'(bus.cr_rd_data[30]), 32'd0);
    cycle();
`else
    drive(3'd0, WRCR, 32'h40, A_COMPARE, 32'd20);
    cycle();
    idle_mem();
    bus.cr_rd_addr = A_COMPARE; #1;
    chk("no_timer_compare", bus.cr_rd_data, 32'd0);
    bus.cr_rd_addr = A_COUNT; #1;
    chk("no_timer_count", bus.cr_rd_data, 32'd0);
    cycle();
`endif

    // Reset asserted in the middle of a redirect cycle.
    drive(3'd3, 2'd0, 32'h700, 5'd0, 32'h0);
    cycle();
    idle_mem();
    chk("pre_reset_level", 32'(bus.exc_level), 32'd1);
    reset = 1;
    #1;
    chk("reset_drops_redirect", 32'(bus.redirect), 32'd0);
    chk("reset_clears_level", 32'(bus.exc_level), 32'd0);
    do_reset();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/cp0_exc_ctrl.md
# cp0_exc_ctrl

Parametrised coprocessor-0 exception controller for the five-stage pipeline. It sits beside the MEM stage and holds the COUNT, COMPARE, STATUS, CAUSE, EPC and PRID registers. It detects masked external and timer interrupts and commits exceptions and returns from the MEM stage. It generalises single-level exception handling to nested exceptions with an EPC/cause/IE stack of configurable depth, a double-fault vector and a parametrised IRQ channel count.

## Interface
- IRQ_CH, 6: number of external interrupt lines (1..16)
- NEST_DEPTH, 2: exception stack depth (1..8)
- EXP_W, 3: exception code width
- PRID_VAL, 32'h0001_0000: constant PRID contents
- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- irq  in  IRQ_CH  level-sensitive interrupt lines
- stall  in  1  pipeline stall (if_busy | mem_busy)
- mem_en  in  1  MEM-stage instruction valid
- mem_pc  in  32  MEM-stage PC
- mem_exp_code  in  EXP_W  MEM-stage exception code; 0 means no exception
- mem_ctrl_op  in  2  NOP / WRCR / EXRT
- mem_cr_addr  in  5  CP0 write address
- mem_cr_wdata  in  32  CP0 write data
- cr_rd_addr  in  5  CP0 read address (ID stage)
- cr_rd_data  out  32  combinational read data
- int_detect  out  1  interrupt request to the ID stage
- int_code  out  EXP_W  code to inject: EXTINT or TIMER
- redirect  out  1  one-cycle flush of IF/ID/EX/MEM
- new_pc  out  32  fetch target, valid while redirect=1
- exc_level  out  $clog2(NEST_DEPTH+1)  current nesting level
- double_fault  out  1  sticky; set on an entry while the stack is full

## Operation
**Register map**
- COUNT=9, COMPARE=11, STATUS=12, CAUSE=13, EPC=14, PRID=15.
- Any other address reads 0; writes to it are ignored.
- STATUS[0]=IE. STATUS[8+:IRQ_CH]=mask, where 1 masks the line.
- CAUSE[EXP_W-1:0]=last committed code. CAUSE[8+:IRQ_CH]=IP, the registered copy of irq. CAUSE[30]=TP, timer pending.
- EPC reads and writes the top stack entry. At level 0, EPC reads 0 and writes to it are ignored.

**Interrupt request**
- int_detect = IE & (|(IP & ~mask) | TP).
- int_code = TIMER if TP, else EXTINT.

**Timer**
- COUNT increments every cycle and wraps 0xFFFF_FFFF to 0.
- TP is set in the cycle COUNT==COMPARE with COMPARE≠0.
- A write to COMPARE clears TP.
- A write to COMPARE wins over a simultaneous match.

**Commit**
- A commit happens when mem_en & !stall and the FSM is in RUN.
- Priority of actions:
  1. mem_exp_code≠0: entry.
     - Push {EPC, CAUSE code, IE}. EPC = mem_pc+4 for TRAP, otherwise mem_pc.
     - Set IE=0 and level+1. new_pc=INT_VECTOR.
     - If the stack is full: set double_fault, no push, level unchanged, new_pc=DF_VECTOR.
  2. EXRT with level>0: pop, restore IE, level-1, new_pc = popped EPC.
  3. EXRT at level 0: no-op with no redirect.
  4. WRCR: write the register, new_pc=mem_pc+4.
- A software write to STATUS may re-enable IE inside a handler. This is what allows nesting.

**FSM**
- RUN → REDIRECT on any entry, return or WRCR commit.
- REDIRECT → RUN unconditionally after one cycle.
- In REDIRECT, MEM-stage inputs are ignored because the stage is being flushed.

## Timing
**Reset values**
- All state: COUNT=COMPARE=0, STATUS=0 (IE=0, no lines masked), CAUSE=0, stack empty.
- All outputs: level=0, redirect=0, new_pc=0, int_detect=0, int_code=0, double_fault=0.
- A reset mid-REDIRECT drops the redirect immediately.

**Latencies**
- irq→IP: 1 cycle. IP→int_detect: combinational.
- irq rising at edge n gives int_detect=1 from cycle n+1, provided it is unmasked and IE=1.
- Commit at cycle T: all register updates happen at edge T+1. redirect=1 with new_pc during cycle T+1 only.
- cr_rd_data reflects state after the last edge; there is no bypass of the current commit.
- stall=1 freezes commits. It does not freeze COUNT or IP.

## Configuration
- CP0_TIMER_EN defined: COUNT, COMPARE and TP behave as above.
- CP0_TIMER_EN undefined:
  - COUNT and COMPARE are not implemented and read 0; writes to them are ignored.
  - TP is tied to 0, so int_code is always EXTINT.

## Structure
- Shared package cp0_pkg holds:
  - register addresses;
  - ctrl op codes (NOP=0, WRCR=1, EXRT=2);
  - exception codes (NOEXP=0, EXTINT=1, TIMER=2, TRAP=3, CP2=4);
  - INT_VECTOR=32'h0000_0080 and DF_VECTOR=32'h0000_0100.
- Sub-module cp0_exc_stack: parametrised LIFO of {epc, code, ie}, NEST_DEPTH entries. Ports: push, pop, top, full, empty, plus a top-write port for EPC writes.

## Test plan
- Reset, then irq[2]=1 with IE=1 and mask=0 → int_detect=1 and int_code=EXTINT one cycle later. Setting mask bit 10 → int_detect=0.
- TRAP commit at mem_pc=0x200 → redirect pulse for exactly one cycle, new_pc=0x80, EPC=0x204, IE=0, level=1. Then EXRT → new_pc=0x204, IE restored, level=0.
- NEST_DEPTH=2: nested entries at 0x300 and 0x400 give level=2. A third entry → new_pc=0x100, double_fault=1, level stays 2. Two EXRTs return to 0x400 then 0x300.
- COMPARE=20 after reset → TP=1 when COUNT==20. A write to COMPARE in the same cycle as the match leaves TP=0.
- Exception commit while stall=1 → no state change until stall falls, then commit. EXRT at level 0 → no redirect.
- Reset asserted during a REDIRECT cycle → redirect=0 and level=0 immediately.
